// File: rtl/audio_codec_rx_stereo_if.sv
// Sample stream leaving the ADC receiver.
//   out_data  : N-bit sample, MSB-aligned as received
//   out_chan  : 0 = left, 1 = right
//   out_valid : a head word is available
//   out_ready : consumer takes the head word when out_valid & out_ready
// master = the receiver (producer), slave = the consumer.
interface audio_codec_rx_stereo_if #(
  parameter int N = 16
);
  logic [N-1:0] out_data;
  logic         out_chan;
  logic         out_valid;
  logic         out_ready;

  modport master (output out_data, output out_chan, output out_valid, input out_ready);
  modport slave  (input out_data, input out_chan, input out_valid, output out_ready);
endinterface

// File: rtl/audio_codec_rx_stereo.sv
// Serial ADC receiver for the audio CODEC.
// Deserialises left/right samples from ADCDAT in left-justified (I2S_MODE=0)
// or I2S (I2S_MODE=1) framing, tags each word with its channel and queues it
// in a small first-word-fall-through FIFO for a valid/ready consumer.
//   bclk, rst      : bit clock (posedge), synchronous active-high reset
//   i_adclrc       : L/R clock, high = left slot, low = right slot
//   i_adcdat       : serial data, MSB first
//   i_clr_flags    : clears the sticky flags (a same-cycle set wins)
//   o_strm         : sample stream (master side of audio_codec_rx_stereo_if)
//   o_fill         : FIFO occupancy, 0..DEPTH
//   o_overflow     : sticky, a completed word was dropped on a full FIFO
//   o_short_frame  : sticky, an LRC edge cut a word short
module audio_codec_rx_stereo #(
  parameter int N        = 16,
  parameter int DEPTH    = 4,
  parameter int I2S_MODE = 0
) (
  input  logic                       bclk,
  input  logic                       rst,
  input  logic                       i_adclrc,
  input  logic                       i_adcdat,
  input  logic                       i_clr_flags,
  audio_codec_rx_stereo_if.master    o_strm,
  output logic [$clog2(DEPTH):0]     o_fill,
  output logic                       o_overflow,
  output logic                       o_short_frame
);
  localparam int IW = $clog2(DEPTH);
  localparam int AW = IW + 1;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SKIP  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_PUSH  = 2'd3;

  logic          r_lrc_q;
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_shreg;
  logic          r_chan;
  logic [N:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic          r_ovf, r_short;

  logic          w_edge, w_push, w_valid, w_full, w_pop, w_wr;
  logic          w_ovf_set, w_short_set;
  logic [AW-1:0] w_fill;

  assign w_edge      = i_adclrc ^ r_lrc_q;
  assign w_push      = (r_state == S_PUSH);
  assign w_fill      = r_wptr - r_rptr;
  assign w_valid     = (w_fill != '0);
  assign w_full      = (w_fill == AW'(DEPTH));
  assign w_pop       = w_valid & o_strm.out_ready;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign w_wr        = w_push & (~w_full | w_pop);
  assign w_ovf_set   = w_push & w_full & ~w_pop;
  assign w_short_set = w_edge & ((r_state == S_SKIP) | (r_state == S_SHIFT));

  // Capture FSM. An edge always restarts capture for the new channel,
  // whatever the state: a partial word is dropped, a pending PUSH still
  // completes because the FIFO write keys off the current state.
  always_ff @(posedge bclk) begin
    if (rst) begin
      r_lrc_q <= 1'b0;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shreg <= '0;
      r_chan  <= 1'b0;
    end else begin
      r_lrc_q <= i_adclrc;
      if (w_edge) begin
        r_chan <= ~i_adclrc;
        if (I2S_MODE != 0) begin
          r_state <= S_SKIP;
          r_cnt   <= '0;
          r_shreg <= '0;
        end else begin
          r_state <= S_SHIFT;
          r_cnt   <= CW'(1);
          r_shreg <= {{(N-1){1'b0}}, i_adcdat};
        end
      end else begin
        case (r_state)
          S_SKIP: begin
            r_state <= S_SHIFT;
            r_cnt   <= CW'(1);
            r_shreg <= {{(N-1){1'b0}}, i_adcdat};
          end
          S_SHIFT: begin
            // Shifting left leaves the first bit at N-1 after N samples.
            r_shreg <= {r_shreg[N-2:0], i_adcdat};
            r_cnt   <= r_cnt + 1'b1;
            if (r_cnt == LAST) r_state <= S_PUSH;
          end
          S_PUSH:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge bclk) begin
    if (w_wr) r_mem[r_wptr[IW-1:0]] <= {r_chan, r_shreg};
  end

  always_ff @(posedge bclk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_ovf   <= 1'b0;
      r_short <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_ovf_set)        r_ovf <= 1'b1;
      else if (i_clr_flags) r_ovf <= 1'b0;
      if (w_short_set)      r_short <= 1'b1;
      else if (i_clr_flags) r_short <= 1'b0;
    end
  end

  assign o_strm.out_data  = r_mem[r_rptr[IW-1:0]][N-1:0];
  assign o_strm.out_chan  = r_mem[r_rptr[IW-1:0]][N];
  assign o_strm.out_valid = w_valid;
  assign o_fill           = w_fill;
  assign o_overflow       = r_ovf;
  assign o_short_frame    = r_short;
endmodule
